var_delay_line: RTL and testbench
=================================

Name: var_delay_line

Overview:
Runtime-programmable delay line built on an internal simple-dual-port RAM. It generalises the fixed-length memory delay chain: the delay is selected at run time (1..MAXLEN enabled cycles), a fill/valid flag is provided, and reset is synchronous. It sits in DSP datapaths (filters, alignment of parallel paths), advancing only on clock-enable strobes.

Parameters:
DW, 8, sample width in bits
MAXLEN, 32, maximum delay in enabled cycles; must be >= 2
DEF_LEN, 16, delay in effect after reset; must be 1..MAXLEN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  clock enable; one sample shifted per clk edge with en=1
din  in  DW  input sample, captured on en edges
len  in  $clog2(MAXLEN+1)  requested delay, sampled only when len_ld=1
len_ld  in  1  single-cycle load strobe for len
cur_len  out  $clog2(MAXLEN+1)  delay currently in effect
dout  out  DW  delayed sample, registered
dvalid  out  1  1 when the line holds cur_len valid samples

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst wins over every other input.
- Reset values: dout=0, dvalid=0, cur_len=DEF_LEN, write pointer=0, fill counter=0.
- Edge index n counts clk edges with en=1. After edge n, dout = din captured at edge n-cur_len+1. With cur_len=1 this is a plain enabled register. With en=0, dout, pointers and counters hold.
- The write pointer wraps modulo MAXLEN, not a power of two. The read address is (wptr - cur_len + 1) mod MAXLEN, computed without overflow for any MAXLEN.
- Length load on a clk edge with len_ld=1:
  - cur_len <= clamp(len): 0 -> 1, >MAXLEN -> MAXLEN.
  - Fill counter <= 0 and dvalid <= 0.
  - The write pointer is not reset.
- Fill state machine, states FILL and RUN:
  - FILL: each en edge writes a sample and increments the fill counter. When the counter reaches cur_len, dvalid goes to 1 on that same edge and the state moves to RUN.
  - RUN: dvalid stays 1 until rst or len_ld.
  - After reset the state is FILL with cur_len=DEF_LEN.
- len_ld and en on the same edge: the new cur_len applies, and the din captured on that edge counts as the first fill sample (counter becomes 1). If cur_len=1, dvalid rises on that edge.
- len_ld while in FILL restarts the fill with the new length.
- No combinational path from din to dout.

Optional Feature:
Macro VAR_DELAY_LINE_MUTE_EN.
- Defined: dout is forced to 0 on every edge where the post-edge dvalid is 0, so stale RAM contents are never visible.
- Undefined: dout shows raw RAM read data during FILL (contents undefined after power-up). dvalid behaviour is identical in both builds.

Decomposition:
- Package var_delay_pkg holds:
  - function clamp_len(len, maxlen)
  - function wrap_sub(a, b, mod) for pointer arithmetic
  - enum type dl_state_e {FILL, RUN}
- Sub-module simple_dp_ram (parameters DW, DEPTH): one write port and one registered read port on the same clk, with read-during-write to different addresses only. It is instantiated once with DEPTH=MAXLEN. The top level holds the pointers, the FSM and the output mute logic.

Test Plan:
- rst, then en=1 continuously with din=1,2,3,... and DEF_LEN=16 -> dvalid rises on the 16th en edge; after edge n (n>=16), dout = n-15.
- len=1, len_ld pulsed together with en, din=0xA5 -> cur_len=1; dvalid=1 and dout=0xA5 after that edge.
- en toggling 1,0,0,1,... with len=4 -> dout changes only on en edges; the delay measured in en edges equals exactly 4, independent of idle cycles.
- len=0 and len=40 with MAXLEN=32 -> cur_len reads 1 and 32 respectively; a 32-delay run wraps the pointer correctly over 100 samples, with no mismatch against the reference model.
- In RUN at len=8, load len=3 -> dvalid=0 for the next 2 en edges, 1 on the 3rd. With VAR_DELAY_LINE_MUTE_EN defined, dout=0 while dvalid=0.
- Assert rst mid-FILL on the same edge as len_ld=1 -> reset values win: cur_len=DEF_LEN, dvalid=0, dout=0.

Source files
------------

// File: rtl/var_delay_pkg.sv
// ---------------------------------------------------------------------------
// var_delay_pkg
// Shared types and helper functions for the runtime-programmable delay line.
//   dl_state_e : fill state machine encoding (FILL, RUN)
//   clamp_len  : maps a requested delay onto the legal range 1..maxlen
//   wrap_sub   : (a - b) mod m for operands already in 0..m-1, overflow-free
// ---------------------------------------------------------------------------
package var_delay_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } dl_state_e;

    // A zero request degenerates to the shortest possible delay.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned maxlen);
        if (len == 0)
            return 1;
        else if (len > maxlen)
            return maxlen;
        else
            return len;
    endfunction

    // Never forms a + m, so it cannot overflow for any modulus.
    function automatic int unsigned wrap_sub(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned m);
        if (a >= b)
            return a - b;
        else
            return m - (b - a);
    endfunction

endpackage

// File: rtl/var_delay_line_ram.sv
// ---------------------------------------------------------------------------
// simple_dp_ram
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Read-during-write is only used with differing addresses.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; the read register holds while low
//   raddr_i  : read address
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module simple_dp_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
        if (re_i)
            rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/var_delay_line.sv
// ---------------------------------------------------------------------------
// var_delay_line
// Runtime-programmable delay line on a simple dual-port RAM. Advances only on
// en strobes; delay selectable 1..MAXLEN; dvalid reports a fully filled line.
// Optional build macro VAR_DELAY_LINE_MUTE_EN: dout reads 0 whenever dvalid
// is 0; without it dout shows raw RAM data while filling.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, overrides all other inputs
//   en      : clock enable, one sample per enabled edge
//   din     : input sample
//   len     : requested delay, taken when len_ld=1
//   len_ld  : single-cycle load strobe
//   cur_len : delay currently in effect
//   dout    : delayed sample
//   dvalid  : line holds cur_len valid samples
// ---------------------------------------------------------------------------
module var_delay_line
    import var_delay_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MAXLEN  = 32,
    parameter int DEF_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [DW-1:0]                din,
    input  logic [$clog2(MAXLEN+1)-1:0]  len,
    input  logic                         len_ld,
    output logic [$clog2(MAXLEN+1)-1:0]  cur_len,
    output logic [DW-1:0]                dout,
    output logic                         dvalid
);

    localparam int LW = $clog2(MAXLEN+1);
    localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    logic [LW-1:0] cur_len_q, cur_len_d;
    logic [LW-1:0] fill_q, fill_d, fill_base;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] raddr;
    dl_state_e     state_q, state_d, state_base;
    logic          dvalid_q, dvalid_d, dvalid_base;
    // Output path: a length-1 bypass register, and a zero flag that covers
    // the post-reset output and the mute build.
    logic [DW-1:0] byp_q;
    logic          sel_byp_q;
    logic          zero_q, zero_d;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        // A load restarts the fill; an en on the same edge is the first sample.
        cur_len_d   = len_ld ? LW'(clamp_len(32'(len), MAXLEN)) : cur_len_q;
        fill_base   = len_ld ? '0   : fill_q;
        state_base  = len_ld ? FILL : state_q;
        dvalid_base = len_ld ? 1'b0 : dvalid_q;

        fill_d   = fill_base;
        state_d  = state_base;
        dvalid_d = dvalid_base;
        if (en && state_base == FILL) begin
            fill_d = fill_base + LW'(1);
            if (fill_d == cur_len_d) begin
                dvalid_d = 1'b1;
                state_d  = RUN;
            end
        end

        wptr_d = wptr_q;
        if (en)
            wptr_d = (wptr_q == AW'(MAXLEN-1)) ? '0 : wptr_q + AW'(1);

        // Sample written cur_len-1 enabled edges ago. Length 1 would alias
        // the write address and is served by the bypass register instead.
        raddr = AW'(wrap_sub(32'(wptr_q), 32'(cur_len_d) - 32'd1, MAXLEN));

`ifdef VAR_DELAY_LINE_MUTE_EN
        zero_d = !dvalid_d ? 1'b1 : (en ? 1'b0 : zero_q);
`else
        zero_d = en ? 1'b0 : zero_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_len_q <= LW'(DEF_LEN);
            fill_q    <= '0;
            wptr_q    <= '0;
            state_q   <= FILL;
            dvalid_q  <= 1'b0;
            byp_q     <= '0;
            sel_byp_q <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            cur_len_q <= cur_len_d;
            fill_q    <= fill_d;
            wptr_q    <= wptr_d;
            state_q   <= state_d;
            dvalid_q  <= dvalid_d;
            zero_q    <= zero_d;
            if (en) begin
                byp_q     <= din;
                sel_byp_q <= (cur_len_d == LW'(1));
            end
        end
    end

    simple_dp_ram #(
        .DW    (DW),
        .DEPTH (MAXLEN),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (en && !rst),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .re_i    (en && !rst),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign cur_len = cur_len_q;
    assign dvalid  = dvalid_q;
    assign dout    = zero_q ? '0 : (sel_byp_q ? byp_q : ram_rdata);

endmodule

// File: tb/tb_var_delay_line.sv
module tb_var_delay_line;

  localparam int DW      = 8;
  localparam int MAXLEN  = 32;
  localparam int DEF_LEN = 16;
  localparam int LW      = $clog2(MAXLEN+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic [LW-1:0] len = '0;
  logic          len_ld = 1'b0;
  logic [LW-1:0] cur_len;
  logic [DW-1:0] dout;
  logic          dvalid;

  int checks = 0;
  int errors = 0;

  // reference model state: full sample history, delay, samples since load
  logic [DW-1:0] hist[$];
  int m_len = DEF_LEN;
  int m_since = 0;
  bit m_any_en = 0;

  typedef struct {
    logic          r;
    logic          e;
    logic          l;
    logic [DW-1:0] d;
    logic [LW-1:0] ln;
    logic [LW-1:0] ecl;
    logic          edv;
    logic          cdo;
    logic [DW-1:0] edo;
  } vec_t;

  vec_t tbl[8];

  var_delay_line #(.DW(DW), .MAXLEN(MAXLEN), .DEF_LEN(DEF_LEN)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .len(len), .len_ld(len_ld),
    .cur_len(cur_len), .dout(dout), .dvalid(dvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampm(input int v);
    if (v == 0) return 1;
    if (v > MAXLEN) return MAXLEN;
    return v;
  endfunction

  // one clock: drive inputs, advance the model, compare #1 after the edge
  task automatic cyc(input logic r, input logic e, input logic [DW-1:0] d,
                     input logic l, input logic [LW-1:0] ln);
    int exp_dv;
    rst = r; en = e; din = d; len_ld = l; len = ln;
    @(posedge clk);
    if (r) begin
      m_len = DEF_LEN; m_since = 0; m_any_en = 0; hist.delete();
    end else begin
      if (l) begin m_len = clampm(int'(ln)); m_since = 0; end
      if (e) begin
        hist.push_back(d);
        if (hist.size() > 64) void'(hist.pop_front());
        m_since++; m_any_en = 1;
      end
    end
    #1;
    exp_dv = (m_since >= m_len) ? 1 : 0;
    chk("cur_len", int'(cur_len), m_len);
    chk("dvalid", int'(dvalid), exp_dv);
    if (exp_dv == 1)
      chk("dout", int'(dout), int'(hist[hist.size()-m_len]));
    else if (!m_any_en)
      chk("dout_rst", int'(dout), 0);
`ifdef VAR_DELAY_LINE_MUTE_EN
    else
      chk("dout_mute", int'(dout), 0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    // table: {rst, en, ld, din, len, exp cur_len, exp dvalid, check dout, exp dout}
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'd0,  6'd16, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 8'hA5, 6'd1,  6'd1,  1'b1, 1'b1, 8'hA5};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h5A, 6'd0,  6'd1,  1'b1, 1'b1, 8'h5A};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'hFF, 6'd0,  6'd1,  1'b1, 1'b1, 8'h5A};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd0,  6'd1,  1'b0, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'd40, 6'd32, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h11, 6'd3,  6'd3,  1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h22, 6'd5,  6'd16, 1'b0, 1'b1, 8'h00};

    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].l, tbl[i].ln);
      chk($sformatf("tbl%0d_cur_len", i), int'(cur_len), int'(tbl[i].ecl));
      chk($sformatf("tbl%0d_dvalid", i), int'(dvalid), int'(tbl[i].edv));
      if (tbl[i].cdo) chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].edo));
    end

    // default length, continuous en, din = 1,2,3,...
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    for (int n = 1; n <= 40; n++) begin
      cyc(1'b0, 1'b1, DW'(n), 1'b0, '0);
      if (n == 15) chk("def_dvalid_n15", int'(dvalid), 0);
      if (n == 16) chk("def_dvalid_n16", int'(dvalid), 1);
      if (n >= 16) chk("def_dout", int'(dout), n - 15);
    end

    // len=4 with idle gaps: delay counted in en edges only
    cyc(1'b0, 1'b0, '0, 1'b1, 6'd4);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, DW'(8'h40 + k), 1'b0, '0);
      if (k >= 4) chk("gap_dout", int'(dout), 8'h40 + k - 3);
      idle(int'($urandom_range(0, 3)));
      if (k >= 4) chk("gap_hold", int'(dout), 8'h40 + k - 3);
    end

    // maximum length over 100 samples exercises the pointer wrap
    cyc(1'b0, 1'b0, '0, 1'b1, 6'd40);
    for (int k = 0; k < 100; k++)
      cyc(1'b0, 1'b1, DW'($urandom), 1'b0, '0);

    // RUN at 8, shorten to 3
    cyc(1'b0, 1'b0, '0, 1'b1, 6'd8);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, DW'($urandom), 1'b0, '0);
    chk("run8_dvalid", int'(dvalid), 1);
    cyc(1'b0, 1'b0, '0, 1'b1, 6'd3);
    chk("ld3_dvalid", int'(dvalid), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b1, DW'($urandom), 1'b0, '0);
      chk("ld3_fill", int'(dvalid), (k == 3) ? 1 : 0);
    end

    // randomized mix
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 9) < 7),
          DW'($urandom),
          ($urandom_range(0, 39) == 0),
          LW'($urandom_range(0, 40)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
